// File: rtl/snake_pkg.sv
// snake_pkg: shared map geometry, LFSR polynomial and food FSM encoding
package snake_pkg;
    localparam int MAP_W = 16;
    localparam int MAP_H = 16;
    localparam int POS_W = 8;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, SCAN = 2'd2} food_state_t;
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction
endpackage

// File: rtl/snake_lfsr16.sv
// snake_lfsr16: free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1
module snake_lfsr16
    import snake_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] out
);
    // shift every cycle; the seed must be non-zero or the sequence locks up
    always_ff @(posedge clk or negedge rst)
        if (!rst) out <= SEED;
        else      out <= lfsr_next(out);
endmodule

// File: rtl/snake_food_gen.sv
// snake_food_gen: random food placement on the 16x16 map; SNAKE_FOOD_SCAN_EN adds a linear-scan fallback
module snake_food_gen
    import snake_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     clr,
    input  logic [MAP_W*MAP_H-1:0]   map_flat,
    output logic [POS_W-1:0]         food_pos,
    output logic                     food_valid,
    output logic                     done,
    output logic                     fail,
    output logic                     busy
);
    logic [15:0]      lfsr;
    logic             unused_lfsr_hi;
    food_state_t      state, state_n;
    logic [POS_W-1:0] cand, cand_n, pos_n;
    logic [3:0]       tries, tries_n;
    logic             valid_n, done_n, fail_n, occ;
`ifdef SNAKE_FOOD_SCAN_EN
    logic [7:0]       scan_cnt, scan_n;
`endif

    snake_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .out(lfsr));

    assign unused_lfsr_hi = ^lfsr[15:8];
    assign occ  = map_flat[cand];
    assign busy = state != IDLE;

    // next-state: clr dominates, then draw / retry / fallback per state
    always_comb begin
        state_n = state;
        cand_n  = cand;
        tries_n = tries;
        pos_n   = food_pos;
        valid_n = food_valid;
        done_n  = 1'b0;
        fail_n  = 1'b0;
`ifdef SNAKE_FOOD_SCAN_EN
        scan_n  = scan_cnt;
`endif
        if (clr) begin
            state_n = IDLE;
            valid_n = 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    cand_n  = lfsr[7:0];
                    tries_n = 4'd1;
                    state_n = CHECK;
                end
                CHECK: if (!occ) begin
                    pos_n   = cand;
                    valid_n = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (tries < 4'(MAX_TRIES)) begin
                    cand_n  = lfsr[7:0];
                    tries_n = tries + 4'd1;
                end else begin
`ifdef SNAKE_FOOD_SCAN_EN
                    cand_n  = cand + 8'd1;
                    scan_n  = 8'd0;
                    state_n = SCAN;
`else
                    fail_n  = 1'b1;
                    state_n = IDLE;
`endif
                end
`ifdef SNAKE_FOOD_SCAN_EN
                SCAN: if (!occ) begin
                    pos_n   = cand;
                    valid_n = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (scan_cnt == 8'd254) begin
                    fail_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cand_n  = cand + 8'd1;
                    scan_n  = scan_cnt + 8'd1;
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    // state and output registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= IDLE;
            cand       <= '0;
            tries      <= '0;
            food_pos   <= '0;
            food_valid <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
`ifdef SNAKE_FOOD_SCAN_EN
            scan_cnt   <= '0;
`endif
        end else begin
            state      <= state_n;
            cand       <= cand_n;
            tries      <= tries_n;
            food_pos   <= pos_n;
            food_valid <= valid_n;
            done       <= done_n;
            fail       <= fail_n;
`ifdef SNAKE_FOOD_SCAN_EN
            scan_cnt   <= scan_n;
`endif
        end
endmodule

// File: tb/tb_snake_food_gen.sv
// tb_snake_food_gen: directed checks of snake_food_gen, with or without SNAKE_FOOD_SCAN_EN
module tb_snake_food_gen;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req = 1'b0;
    logic         clr = 1'b0;
    logic [255:0] map_flat = '0;
    logic [7:0]   food_pos;
    logic         food_valid, done, fail, busy;
    logic [15:0]  m_lfsr;
    int           checks = 0;
    int           errors = 0;

    snake_food_gen dut (
        .clk(clk), .rst(rst), .req(req), .clr(clr), .map_flat(map_flat),
        .food_pos(food_pos), .food_valid(food_valid), .done(done), .fail(fail), .busy(busy)
    );

    always #5 clk = ~clk;

    // reference LFSR built from the polynomial mask
    always @(posedge clk or negedge rst)
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // called at a negedge: one-cycle req, returns the candidate the DUT samples
    task automatic fire(output logic [7:0] e);
        req = 1'b1;
        e = m_lfsr[7:0];
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_ev(input int bound, output int lat, output logic d, output logic f);
        lat = 0;
        while (lat < bound && !(done || fail)) begin
            @(negedge clk);
            lat++;
        end
        d = done;
        f = fail;
        if (!(d || f)) chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0]  e, p0;
        logic [15:0] s;
        logic        d, f, v0;
        int          lat, hit, evs;
        repeat (3) @(negedge clk);
        chk("rst_pos", food_pos, 8'h00);
        chk("rst_valid", food_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fail", fail, 1'b0);
        rst = 1'b1;
        #1 chk("rst_seed", dut.u_lfsr.out, 16'hACE1);
        @(negedge clk);

        // empty map: first draw is always free
        map_flat = '0;
        fire(e);
        chk("empty_busy", busy, 1'b1);
        wait_ev(4, lat, d, f);
        chk("empty_done", d, 1'b1);
        chk("empty_lat", lat, 1);
        chk("empty_pos", food_pos, e);
        chk("empty_valid", food_valid, 1'b1);
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        chk("idle_after", busy, 1'b0);

        // single free cell 5A: predict which of the 8 draws hits it
        map_flat = '1;
        map_flat[8'h5A] = 1'b0;
        p0 = food_pos;
        s = m_lfsr;
        hit = -1;
        for (int i = 0; i < 8; i++) begin
            if (hit < 0 && s[7:0] == 8'h5A) hit = i;
            s = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
        end
        fire(e);
        wait_ev(270, lat, d, f);
`ifdef SNAKE_FOOD_SCAN_EN
        chk("one_done", d, 1'b1);
        chk("one_pos", food_pos, 8'h5A);
        if (hit >= 0) chk("one_lat", lat, hit + 1);
`else
        if (hit >= 0) begin
            chk("one_done", d, 1'b1);
            chk("one_pos", food_pos, 8'h5A);
            chk("one_lat", lat, hit + 1);
        end else begin
            chk("one_fail", f, 1'b1);
            chk("one_pos_kept", food_pos, p0);
            chk("one_lat", lat, 8);
        end
`endif
        @(negedge clk);

        // full map: must fail, previous food kept
        map_flat = '1;
        p0 = food_pos;
        v0 = food_valid;
        fire(e);
        wait_ev(270, lat, d, f);
        chk("full_fail", f, 1'b1);
        chk("full_nodone", d, 1'b0);
`ifdef SNAKE_FOOD_SCAN_EN
        chk("full_lat", lat, 263);
`else
        chk("full_lat", lat, 8);
`endif
        chk("full_pos", food_pos, p0);
        chk("full_valid", food_valid, v0);
        @(negedge clk);
        chk("fail_pulse", fail, 1'b0);

        // req pulses while busy are dropped
        fire(e);
        evs = 0;
        for (int i = 0; i < 300; i++) begin
            if (done || fail) evs++;
            req = busy && (i % 5 == 2);
            @(negedge clk);
        end
        req = 1'b0;
        chk("busy_req_events", evs, 1);
        chk("busy_req_idle", busy, 1'b0);

        // clr mid-operation, after a placed food
        map_flat = '0;
        fire(e);
        wait_ev(4, lat, d, f);
        chk("pre_clr_valid", food_valid, 1'b1);
        @(negedge clk);
        map_flat = '1;
        fire(e);
`ifdef SNAKE_FOOD_SCAN_EN
        repeat (48) @(negedge clk);
        chk("clr_scan_cnt", dut.scan_cnt, 8'd40);
`else
        repeat (3) @(negedge clk);
`endif
        clr = 1'b1;
        req = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        req = 1'b0;
        chk("clr_busy", busy, 1'b0);
        chk("clr_valid", food_valid, 1'b0);
        chk("clr_done", done, 1'b0);
        chk("clr_fail", fail, 1'b0);
        @(negedge clk);
        chk("clr_req_dropped", busy, 1'b0);
        map_flat = '0;
        fire(e);
        chk("restart_busy", busy, 1'b1);
        wait_ev(4, lat, d, f);
        chk("restart_done", d, 1'b1);
        chk("restart_pos", food_pos, e);
        @(negedge clk);

        // asynchronous reset mid-operation
        map_flat = '1;
        fire(e);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_pos", food_pos, 8'h00);
        chk("arst_valid", food_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_fail", fail, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("arst_seed", dut.u_lfsr.out, 16'hACE1);
        @(negedge clk);
        map_flat = '0;
        fire(e);
        wait_ev(4, lat, d, f);
        chk("post_rst_pos", food_pos, e);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
